// File: rtl/ga_eval_sequencer_pkg.sv
// ga_eval_pkg: shared FSM state type and error-accumulation helpers for the evaluation sequencer.
package ga_eval_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT_MEM,
        S_ISSUE,
        S_WAIT_EVAL,
        S_ACC,
        S_DONE
    } state_t;

    // Widest ceiling; narrower accumulators shift it down to their own width.
    localparam logic [63:0] ERR_MAX = '1;

    function automatic int pop_w(input int w);
        return $clog2(w + 1);
    endfunction

    function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b, input int w);
        logic [64:0] s;
        logic [63:0] m;
        m = ERR_MAX >> (64 - w);
        s = {1'b0, a} + {1'b0, b};
        return (s > {1'b0, m}) ? m : s[63:0];
    endfunction

endpackage

// File: rtl/ga_eval_sequencer_if.sv
// ga_eval_sequencer_if: HPS handshake, memory s2 ports, circuit-array strobe and error sums.
interface ga_eval_sequencer_if #(
    parameter int N_CH   = 8,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 15,
    parameter int ERR_W  = 32
);
    logic                     start_processing_chrom;
    logic [31:0]              sequences_to_process;
    logic [DATA_W-1:0]        valid_mask;
    logic                     ready_to_process;
    logic                     done_processing_chrom;
    logic [ADDR_W-1:0]        mem_s2_address;
    logic                     mem_s2_chipselect;
    logic                     mem_s2_clken;
    logic [DATA_W-1:0]        mem_s2_readdata;
    logic [ADDR_W-1:0]        correct_mem_s2_address;
    logic                     correct_mem_s2_chipselect;
    logic                     correct_mem_s2_clken;
    logic [DATA_W-1:0]        correct_mem_s2_readdata;
    logic [DATA_W-1:0]        eval_input;
    logic                     eval_valid;
    logic [N_CH*DATA_W-1:0]   eval_output;
    logic                     eval_output_valid;
    logic [N_CH*ERR_W-1:0]    error_sum;

    modport master (
        input  start_processing_chrom, sequences_to_process, valid_mask,
               mem_s2_readdata, correct_mem_s2_readdata, eval_output, eval_output_valid,
        output ready_to_process, done_processing_chrom,
               mem_s2_address, mem_s2_chipselect, mem_s2_clken,
               correct_mem_s2_address, correct_mem_s2_chipselect, correct_mem_s2_clken,
               eval_input, eval_valid, error_sum
    );

    modport slave (
        output start_processing_chrom, sequences_to_process, valid_mask,
               mem_s2_readdata, correct_mem_s2_readdata, eval_output, eval_output_valid,
        input  ready_to_process, done_processing_chrom,
               mem_s2_address, mem_s2_chipselect, mem_s2_clken,
               correct_mem_s2_address, correct_mem_s2_chipselect, correct_mem_s2_clken,
               eval_input, eval_valid, error_sum
    );

endinterface

// File: rtl/ga_eval_sequencer_err_channel.sv
// ga_err_channel: masked Hamming distance of one circuit output, saturating accumulation.
module ga_err_channel
    import ga_eval_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ERR_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clr,
    input  logic              i_en,
    input  logic [DATA_W-1:0] i_out,
    input  logic [DATA_W-1:0] i_exp,
    input  logic [DATA_W-1:0] i_mask,
    output logic [ERR_W-1:0]  o_sum
);
    localparam int PW = pop_w(DATA_W);

    logic [DATA_W-1:0] w_diff;
    logic [PW-1:0]     w_err;
    logic [ERR_W-1:0]  r_sum;

    always_comb begin
        w_diff = (i_out ^ i_exp) & i_mask;
        w_err  = '0;
        for (int i = 0; i < DATA_W; i++) w_err = w_err + PW'(w_diff[i]);
    end

    always_ff @(posedge clk) begin
        if (rst || i_clr) r_sum <= '0;
        else if (i_en) r_sum <= ERR_W'(sat_add(64'(r_sum), 64'(w_err), ERR_W));
    end

    assign o_sum = r_sum;

endmodule

// File: rtl/ga_eval_sequencer.sv
// ga_eval_sequencer: runs one evaluation pass per HPS start, accumulating per-channel error sums.
module ga_eval_sequencer
    import ga_eval_pkg::*;
#(
    parameter int N_CH   = 8,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 15,
    parameter int ERR_W  = 32
) (
    input logic                 clk_clk,
    input logic                 reset_reset,
    ga_eval_sequencer_if.master bus
);
    state_t                 r_state, w_next;
    logic [ADDR_W-1:0]      r_index, r_last, w_last;
    logic [DATA_W-1:0]      r_mask, r_sample, r_exp;
    logic [N_CH*DATA_W-1:0] r_out;
    logic [N_CH*ERR_W-1:0]  w_sum;
    logic                   w_start, w_zero, w_big, w_clr, w_acc;

    assign w_start = bus.start_processing_chrom;
    assign w_zero  = bus.sequences_to_process == 32'd0;
    assign w_big   = {1'b0, bus.sequences_to_process} > (33'd1 << ADDR_W);
    // Store count-1 so the clamped 2^ADDR_W case still fits the index width.
    assign w_last  = w_big ? '1 : ADDR_W'(bus.sequences_to_process - 32'd1);
    assign w_clr   = (r_state == S_IDLE) && w_start;
    assign w_acc   = r_state == S_ACC;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:      if (w_start) w_next = w_zero ? S_DONE : S_FETCH;
            S_FETCH:     w_next = S_WAIT_MEM;
            S_WAIT_MEM:  w_next = S_ISSUE;
            S_ISSUE:     w_next = S_WAIT_EVAL;
            S_WAIT_EVAL: if (bus.eval_output_valid) w_next = S_ACC;
            S_ACC:       w_next = (r_index == r_last) ? S_DONE : S_FETCH;
            S_DONE:      if (!w_start) w_next = S_IDLE;
            default:     w_next = S_IDLE;
        endcase
        if (!w_start && r_state != S_IDLE && r_state != S_DONE) w_next = S_IDLE;
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_state  <= S_IDLE;
            r_index  <= '0;
            r_last   <= '0;
            r_mask   <= '0;
            r_sample <= '0;
            r_exp    <= '0;
            r_out    <= '0;
        end else begin
            r_state <= w_next;
            if (w_clr) begin
                r_index <= '0;
                r_last  <= w_last;
                r_mask  <= bus.valid_mask;
            end
            if (w_acc && r_index != r_last) r_index <= r_index + 1'b1;
            if (r_state == S_WAIT_MEM) begin
                r_sample <= bus.mem_s2_readdata;
                r_exp    <= bus.correct_mem_s2_readdata;
            end
            if (r_state == S_WAIT_EVAL && bus.eval_output_valid) r_out <= bus.eval_output;
        end
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        ga_err_channel #(.DATA_W(DATA_W), .ERR_W(ERR_W)) u_ch (
            .clk    (clk_clk),
            .rst    (reset_reset),
            .i_clr  (w_clr),
            .i_en   (w_acc),
            .i_out  (r_out[c*DATA_W +: DATA_W]),
            .i_exp  (r_exp),
            .i_mask (r_mask),
            .o_sum  (w_sum[c*ERR_W +: ERR_W])
        );
    end

    assign bus.ready_to_process          = r_state == S_IDLE;
    assign bus.done_processing_chrom     = r_state == S_DONE;
    assign bus.mem_s2_address            = r_index;
    assign bus.mem_s2_chipselect         = r_state == S_FETCH;
    assign bus.mem_s2_clken              = 1'b1;
    assign bus.correct_mem_s2_address    = r_index;
    assign bus.correct_mem_s2_chipselect = r_state == S_FETCH;
    assign bus.correct_mem_s2_clken      = 1'b1;
    assign bus.eval_input                = r_sample;
    assign bus.eval_valid                = r_state == S_ISSUE;
    assign bus.error_sum                 = w_sum;

endmodule

// File: tb/tb_ga_eval_sequencer.sv
// tb_ga_eval_sequencer: memory and circuit-array models with a sample/address scoreboard and error-sum model.
module tb_ga_eval_sequencer;
    localparam int N_CH    = 8;
    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 15;
    localparam int ERR_W   = 6;
    localparam int SUM_MAX = (1 << ERR_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ga_eval_sequencer_if #(.N_CH(N_CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ERR_W(ERR_W)) bus ();

    ga_eval_sequencer #(.N_CH(N_CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ERR_W(ERR_W)) dut (
        .clk_clk     (clk),
        .reset_reset (rst),
        .bus         (bus)
    );

    int total = 0;
    int bad = 0;
    int cs_cnt = 0;
    int ev_cnt = 0;
    int lat = 2;
    int cnt;
    logic pend;
    logic [DATA_W-1:0] in_mem [16];
    logic [DATA_W-1:0] exp_mem [16];
    logic [DATA_W-1:0] resp [N_CH];
    logic [DATA_W-1:0] cur_mask;
    logic [DATA_W-1:0] q_sample [$];
    int q_addr [$];
    int mon_addr;
    logic [DATA_W-1:0] mon_sample;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model_sum(input int c, input int k);
        int s = 0;
        for (int i = 0; i < k; i++) s += $countones((resp[c] ^ exp_mem[i]) & cur_mask);
        return 64'(s > SUM_MAX ? SUM_MAX : s);
    endfunction

    function automatic logic [63:0] dut_sum(input int c);
        return 64'(bus.error_sum[c*ERR_W +: ERR_W]);
    endfunction

    // Both on-chip memories: registered read, one cycle latency.
    always @(posedge clk) begin
        if (bus.mem_s2_chipselect) bus.mem_s2_readdata <= in_mem[bus.mem_s2_address[3:0]];
        if (bus.correct_mem_s2_chipselect) bus.correct_mem_s2_readdata <= exp_mem[bus.correct_mem_s2_address[3:0]];
    end

    // Circuit array: answers each eval_valid after lat idle cycles.
    always @(posedge clk) begin
        bus.eval_output_valid <= 1'b0;
        if (rst) pend <= 1'b0;
        else if (bus.eval_valid) begin
            pend <= 1'b1;
            cnt  <= lat;
        end else if (pend) begin
            if (cnt == 0) begin
                pend <= 1'b0;
                bus.eval_output_valid <= 1'b1;
                for (int c = 0; c < N_CH; c++) bus.eval_output[c*DATA_W +: DATA_W] <= resp[c];
            end else cnt <= cnt - 1;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.mem_s2_chipselect) begin
                cs_cnt++;
                if (q_addr.size() == 0) check_eq("cs_extra", 64'(bus.mem_s2_chipselect), 64'd0);
                else begin
                    mon_addr = q_addr.pop_front();
                    check_eq("addr", 64'(bus.mem_s2_address), 64'(mon_addr));
                    check_eq("caddr", 64'(bus.correct_mem_s2_address), 64'(mon_addr));
                    check_eq("ccs", 64'(bus.correct_mem_s2_chipselect), 64'd1);
                end
            end
            if (bus.eval_valid) begin
                ev_cnt++;
                if (q_sample.size() == 0) check_eq("ev_extra", 64'(bus.eval_valid), 64'd0);
                else begin
                    mon_sample = q_sample.pop_front();
                    check_eq("eval_input", 64'(bus.eval_input), 64'(mon_sample));
                end
            end
        end
    end

    task automatic check_sums(input string tag, input int k);
        for (int c = 0; c < N_CH; c++) check_eq(tag, dut_sum(c), model_sum(c, k));
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, "_ready"}, 64'(bus.ready_to_process), 64'd1);
        check_eq({tag, "_done"}, 64'(bus.done_processing_chrom), 64'd0);
        check_eq({tag, "_cs"}, 64'(bus.mem_s2_chipselect), 64'd0);
        check_eq({tag, "_ccs"}, 64'(bus.correct_mem_s2_chipselect), 64'd0);
        check_eq({tag, "_ev"}, 64'(bus.eval_valid), 64'd0);
        check_eq({tag, "_addr"}, 64'(bus.mem_s2_address), 64'd0);
        check_eq({tag, "_caddr"}, 64'(bus.correct_mem_s2_address), 64'd0);
        check_eq({tag, "_in"}, 64'(bus.eval_input), 64'd0);
        check_eq({tag, "_clken"}, 64'({bus.mem_s2_clken, bus.correct_mem_s2_clken}), 64'd3);
        for (int c = 0; c < N_CH; c++) check_eq({tag, "_sum"}, dut_sum(c), 64'd0);
    endtask

    task automatic begin_pass(input int n, input logic [DATA_W-1:0] m);
        cur_mask = m;
        for (int i = 0; i < n; i++) begin
            q_addr.push_back(i);
            q_sample.push_back(in_mem[i]);
        end
        bus.valid_mask = m;
        bus.sequences_to_process = n;
        bus.start_processing_chrom = 1'b1;
    endtask

    task automatic wait_ev(input string tag, input int target, input int lim);
        int t = 0;
        while (ev_cnt < target && t < lim) begin
            @(negedge clk);
            t++;
        end
        check_eq({tag, "_ev_timeout"}, 64'(ev_cnt >= target), 64'd1);
    endtask

    task automatic run_pass(input string tag, input int n, input logic [DATA_W-1:0] m);
        int cs0 = cs_cnt;
        int ev0 = ev_cnt;
        int t = 0;
        int lim = n * (lat + 8) + 2;
        begin_pass(n, m);
        while (!bus.done_processing_chrom && t < lim) begin
            @(negedge clk);
            t++;
        end
        check_eq({tag, "_done"}, 64'(bus.done_processing_chrom), 64'd1);
        check_eq({tag, "_ready"}, 64'(bus.ready_to_process), 64'd0);
        check_sums({tag, "_sum"}, n);
        check_eq({tag, "_cs_n"}, 64'(cs_cnt - cs0), 64'(n));
        check_eq({tag, "_ev_n"}, 64'(ev_cnt - ev0), 64'(n));
        check_eq({tag, "_left"}, 64'(q_sample.size() + q_addr.size()), 64'd0);
        repeat (3) @(negedge clk);
        check_eq({tag, "_done_hold"}, 64'(bus.done_processing_chrom), 64'd1);
        check_sums({tag, "_sum_hold"}, n);
        bus.start_processing_chrom = 1'b0;
        @(negedge clk);
        check_eq({tag, "_back_ready"}, 64'(bus.ready_to_process), 64'd1);
        check_eq({tag, "_back_done"}, 64'(bus.done_processing_chrom), 64'd0);
    endtask

    initial begin
        int ev0;
        int cs0;
        logic [DATA_W-1:0] m;
        bus.start_processing_chrom = 1'b0;
        bus.sequences_to_process = '0;
        bus.valid_mask = '0;
        repeat (3) @(negedge clk);
        check_idle("rst");
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            in_mem[i]  = DATA_W'(i);
            exp_mem[i] = 32'hFF;
        end
        for (int c = 0; c < N_CH; c++) resp[c] = 32'hFF;
        resp[3] = 32'h0F;
        run_pass("basic", 4, 32'hFF);
        run_pass("zero", 0, 32'hFF);
        for (int i = 0; i < 16; i++) begin
            in_mem[i]  = 32'hA5A5_0000 | DATA_W'(i);
            exp_mem[i] = '0;
        end
        for (int c = 0; c < N_CH; c++) resp[c] = '1;
        run_pass("mask", 2, 32'h0000_FFFF);
        run_pass("sat", 3, 32'hFFFF_FFFF);
        for (int i = 0; i < 16; i++) begin
            in_mem[i]  = $urandom;
            exp_mem[i] = $urandom;
        end
        for (int c = 0; c < N_CH; c++) resp[c] = $urandom;
        lat = 3;
        m = $urandom;
        run_pass("rand", 5, m);
        lat = 20;
        ev0 = ev_cnt;
        begin_pass(4, m);
        wait_ev("abort", ev0 + 2, 80);
        repeat (3) @(negedge clk);
        bus.start_processing_chrom = 1'b0;
        @(negedge clk);
        check_eq("abort_ready", 64'(bus.ready_to_process), 64'd1);
        check_eq("abort_done", 64'(bus.done_processing_chrom), 64'd0);
        check_sums("abort_part", 1);
        q_addr.delete();
        q_sample.delete();
        repeat (30) @(negedge clk);
        check_eq("abort_done_late", 64'(bus.done_processing_chrom), 64'd0);
        check_sums("abort_hold", 1);
        run_pass("rerun", 4, m);
        lat = 100;
        ev0 = ev_cnt;
        cs0 = cs_cnt;
        begin_pass(3, m);
        wait_ev("bp", ev0 + 1, 20);
        repeat (50) @(negedge clk);
        check_eq("bp_ev_single", 64'(ev_cnt - ev0), 64'd1);
        check_eq("bp_cs_single", 64'(cs_cnt - cs0), 64'd1);
        check_sums("bp_stall", 0);
        wait_ev("bp2", ev0 + 2, 200);
        check_sums("bp_one", 1);
        rst = 1'b1;
        bus.start_processing_chrom = 1'b0;
        @(negedge clk);
        check_idle("mid_rst");
        rst = 1'b0;
        q_addr.delete();
        q_sample.delete();
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
